// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM loader: default widths and the FSM state encoding.
package ram_loader_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ram_loader_sync_ram.sv
// Single write port, single registered read port memory; read-first on address collision.
module sync_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never cleared; only the output register sees reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/ram_loader.sv
// Streams exactly 2**ADDR_W words into a memory after a start request, keeping a running checksum.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              we;
  logic              begin_load;

  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (din_valid && (wr_addr == '1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign we         = din_ready & din_valid;
  assign begin_load = (state == IDLE) & start;

  // wr_addr wraps to 0 on its own after the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr  <= '0;
      checksum <= '0;
    end else if (begin_load) begin
      wr_addr  <= '0;
      checksum <= '0;
    end else if (we) begin
      wr_addr  <= wr_addr + 1'b1;
      checksum <= wrap_add(checksum, din);
    end
  end

  sync_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(din),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_ram_loader.sv
// Randomized self-checking bench for ram_loader against a word-count based reference model.
module tb_ram_loader;
  import ram_loader_pkg::*;

  localparam int DW    = DEF_DATA_W;
  localparam int AW    = DEF_ADDR_W;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  ram_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: words accepted so far in the current load, plus a shadow memory.
  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  bit            m_active  = 1'b0;
  bit            m_done    = 1'b0;
  int            m_count   = 0;
  logic [DW-1:0] m_sum     = '0;
  logic [DW-1:0] m_rd      = '0;
  bit            m_rd_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("din_ready", 32'(din_ready), 32'(m_active));
    chk("busy", 32'(busy), 32'(m_active | m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("checksum", 32'(checksum), 32'(m_sum));
    if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  task automatic step(input logic s, input logic v, input logic [DW-1:0] d,
                      input logic [AW-1:0] ra);
    start     = s;
    din_valid = v;
    din       = d;
    rd_addr   = ra;
    @(posedge clk);
    m_rd_known = ref_known[ra];
    m_rd       = ref_mem[ra];
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (v) begin
        ref_mem[m_count]   = d;
        ref_known[m_count] = 1'b1;
        m_sum              = m_sum + d;
        m_count++;
        if (m_count == DEPTH) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_count  = 0;
        end
      end
    end else if (s) begin
      m_active = 1'b1;
      m_count  = 0;
      m_sum    = '0;
    end
    #1 check_outputs();
    @(negedge clk);
  endtask

  task automatic async_reset();
    start     = 1'b0;
    din_valid = 1'b0;
    reset     = 1'b1;
    #1;
    m_active   = 1'b0;
    m_done     = 1'b0;
    m_count    = 0;
    m_sum      = '0;
    m_rd       = '0;
    m_rd_known = 1'b1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic full_random_load();
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'($urandom), AW'($urandom_range(DEPTH-1)));
    step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] old5;
    logic [DW-1:0] new_w [5];
    int            w;
    reset     = 1'b0;
    start     = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    rd_addr   = '0;

    #2 reset = 1'b1;
    #1;
    m_rd_known = 1'b1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full load of 0x00..0x1F
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, DW'(i), '0);
      if (i < DEPTH - 1) chk("full_no_early_done", 32'(done), 32'd0);
    end
    chk("full_done", 32'(done), 32'd1);
    chk("full_sum", 32'(checksum), 32'hF0);
    step(1'b0, 1'b0, '0, AW'(5'h1F));
    chk("full_rd1f", 32'(rd_data), 32'h1F);
    chk("done_one_cycle", 32'(done), 32'd0);

    // Idle gating: valid data with no start must not be written
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, DW'($urandom), AW'(i));
      chk("idle_ready", 32'(din_ready), 32'd0);
    end
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, '0, AW'(a));

    // Gapped load of 0xFF words
    step(1'b1, 1'b0, '0, '0);
    w = 0;
    for (int c = 0; c < 200 && w < DEPTH; c++) begin
      step(1'b0, (c % 2) == 0, DW'(8'hFF), AW'($urandom_range(DEPTH-1)));
      if ((c % 2) == 0) w++;
    end
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_sum", 32'(checksum), 32'hE0);
    step(1'b0, 1'b0, '0, '0);

    // Read-during-write on address 3
    step(1'b1, 1'b0, '0, AW'(3));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, (i == 3) ? DW'(8'h11) : DW'($urandom), AW'(3));
    step(1'b0, 1'b0, '0, AW'(3));
    step(1'b1, 1'b0, '0, AW'(3));
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, (i == 3) ? DW'(8'hAA) : DW'($urandom), AW'(3));
      if (i == 3) chk("rdw_old", 32'(rd_data), 32'h11);
      if (i == 4) chk("rdw_new", 32'(rd_data), 32'hAA);
    end
    step(1'b0, 1'b0, '0, '0);

    // Start pulse while busy is ignored
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) step(i == 10, 1'b1, DW'($urandom), AW'($urandom_range(DEPTH-1)));
    chk("busy_start_done", 32'(done), 32'd1);
    step(1'b1, 1'b0, '0, '0);
    chk("done_start_ignored", 32'(busy), 32'd0);

    // Reset after five words of a load
    full_random_load();
    old5 = ref_mem[5];
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      new_w[i] = DW'($urandom);
      step(1'b0, 1'b1, new_w[i], '0);
    end
    async_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(checksum), 32'd0);
    step(1'b0, 1'b0, '0, AW'(5));
    chk("rst_old5", 32'(rd_data), 32'(old5));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, AW'(i));
      chk("rst_new", 32'(rd_data), 32'(new_w[i]));
    end
    full_random_load();

    // Random traffic with occasional asynchronous resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(199) == 0) async_reset();
      step($urandom_range(9) == 0, 1'($urandom), DW'($urandom), AW'($urandom_range(DEPTH-1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
